// File: rtl/data_ram_lat.sv
// Latency-configurable data RAM model for the core's LSU data port.
// Adds programmable read/write latency, periodic stall injection and error flagging.
module data_ram_lat #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 65536,
  parameter int RD_LAT       = 1,
  parameter int WR_LAT       = 0,
  parameter int STALL_PERIOD = 0,
  parameter int STALL_CYCLES = 3,
  localparam int BEW         = WIDTH / 8,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      data_addr_i,
  input  logic [WIDTH-1:0] store_data_i,
  input  logic [BEW-1:0]   byte_enable_i,
  input  logic             MemR_en_i,
  input  logic             MemW_en_i,
  output logic [WIDTH-1:0] load_data_o,
  output logic             read_valid_o,
  output logic             write_ready_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a request is held by the requester until accepted, and is accepted
  // only in IDLE (writes additionally need write_ready_o=1); read_valid_o is a
  // one-cycle completion pulse with load_data_o valid in that same cycle.

  localparam int          BW     = $clog2(BEW);
  localparam int          MAXLAT = ((RD_LAT > WR_LAT) ? RD_LAT : WR_LAT) + STALL_CYCLES;
  localparam int          CW     = $clog2(MAXLAT + 1);
  localparam int unsigned SP     = (STALL_PERIOD == 0) ? 1 : STALL_PERIOD;
  localparam logic [32:0] LIMIT  = 33'(DEPTH * BEW);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2,
    WR_BUSY = 2'd3
  } state_t;

  state_t           state, next_state;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [15:0]      acc_cnt;
  logic [WIDTH-1:0] rd_buf;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             rd_acc, wr_acc, illegal;
  logic             in_range, stall;
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] sample;
  logic [CW-1:0]    stall_add, rd_lat, wr_lat;

  assign in_range  = ({1'b0, data_addr_i} < LIMIT);
  assign idx       = data_addr_i[AW+BW-1:BW];
  assign sample    = in_range ? mem[idx] : '0;
  assign stall     = (STALL_PERIOD != 0) && ((32'(acc_cnt) % SP) == SP - 1);
  assign stall_add = stall ? CW'(STALL_CYCLES) : '0;
  assign rd_lat    = CW'(RD_LAT) + stall_add;
  assign wr_lat    = CW'(WR_LAT) + stall_add;

  assign write_ready_o = (state == IDLE);
  assign busy_o        = (state != IDLE);
  assign read_valid_o  = (state == RD_RESP);
  assign dbg_state_o   = state;

  always_comb begin
    next_state = state;
    cnt_nxt    = cnt;
    rd_acc     = 1'b0;
    wr_acc     = 1'b0;
    illegal    = 1'b0;
    case (state)
      IDLE: begin
        if (MemR_en_i && MemW_en_i) begin
          illegal = 1'b1;
        end else if (MemR_en_i) begin
          rd_acc = 1'b1;
          if (rd_lat == CW'(1)) begin
            next_state = RD_RESP;
          end else begin
            next_state = RD_WAIT;
            cnt_nxt    = rd_lat - CW'(1);
          end
        end else if (MemW_en_i && write_ready_o) begin
          wr_acc = 1'b1;
          if (wr_lat != '0) begin
            next_state = WR_BUSY;
            cnt_nxt    = wr_lat;
          end
        end
      end
      RD_WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) next_state = RD_RESP;
      end
      RD_RESP: next_state = IDLE;
      WR_BUSY: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc_cnt     <= '0;
      load_data_o <= '0;
      rd_buf      <= '0;
      err_o       <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_nxt;
      err_o <= illegal | ((rd_acc | wr_acc) & ~in_range);
      if (rd_acc | wr_acc) acc_cnt <= acc_cnt + 16'd1;
      // Read data is frozen at accept so later writes cannot alter the response.
      if (rd_acc) rd_buf <= sample;
      if (next_state == RD_RESP) load_data_o <= (state == IDLE) ? sample : rd_buf;
    end
  end

  // Storage is deliberately not reset; writes commit at the accept edge.
  always_ff @(posedge clk) begin
    if (rst && wr_acc && in_range) begin
      for (int b = 0; b < BEW; b++) begin
        if (byte_enable_i[b]) mem[idx][b*8 +: 8] <= store_data_i[b*8 +: 8];
      end
    end
  end

endmodule
